// File: rtl/except_collector_pkg.sv
// except_collector shared definitions: widths, stage indices,
// cause codes, FSM encoding and the fixed-priority grant helper.
package except_collector_pkg;

    localparam int XLEN_DEF = 32;
    localparam int EXW_DEF  = 4;
    localparam int NSTG     = 4;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;

    localparam logic [EXW_DEF-1:0] CAUSE_INSN_MISALIGN  = 4'd0;
    localparam logic [EXW_DEF-1:0] CAUSE_INSN_FAULT     = 4'd1;
    localparam logic [EXW_DEF-1:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [EXW_DEF-1:0] CAUSE_BREAKPOINT     = 4'd3;
    localparam logic [EXW_DEF-1:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [EXW_DEF-1:0] CAUSE_LOAD_FAULT     = 4'd5;
    localparam logic [EXW_DEF-1:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [EXW_DEF-1:0] CAUSE_STORE_FAULT    = 4'd7;
    localparam logic [EXW_DEF-1:0] CAUSE_ECALL_M        = 4'd11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_KILL   = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_REPORT = 3'd3;
    localparam logic [2:0] ST_REDIR  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_KILL   = ST_KILL,
        S_DRAIN  = ST_DRAIN,
        S_REPORT = ST_REPORT,
        S_REDIR  = ST_REDIR
    } state_t;

    // Oldest stage wins: MEM > EX > ID > IF.
    function automatic logic [NSTG-1:0] prio_grant(
        input logic [NSTG-1:0] req
    );
        logic [NSTG-1:0] g;
        g = '0;
        if (req[STG_MEM])     g[STG_MEM] = 1'b1;
        else if (req[STG_EX]) g[STG_EX]  = 1'b1;
        else if (req[STG_ID]) g[STG_ID]  = 1'b1;
        else if (req[STG_IF]) g[STG_IF]  = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/except_collector_prio_sel.sv
// exc_prio_sel: combinational 4-way fixed-priority select of the
// per-stage exception reports; one-hot grant plus muxed record.
module exc_prio_sel
    import except_collector_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int EXW  = EXW_DEF
) (
    input  logic [NSTG-1:0]      valid,
    input  logic [NSTG*EXW-1:0]  cause,
    input  logic [NSTG*XLEN-1:0] pc,
    input  logic [NSTG*XLEN-1:0] tval,
    output logic [NSTG-1:0]      grant,
    output logic [EXW-1:0]       sel_cause,
    output logic [XLEN-1:0]      sel_pc,
    output logic [XLEN-1:0]      sel_tval
);

    always_comb begin
        grant     = prio_grant(valid);
        sel_cause = '0;
        sel_pc    = '0;
        sel_tval  = '0;
        unique case (1'b1)
            grant[STG_MEM]: begin
                sel_cause = cause[STG_MEM*EXW +: EXW];
                sel_pc    = pc[STG_MEM*XLEN +: XLEN];
                sel_tval  = tval[STG_MEM*XLEN +: XLEN];
            end
            grant[STG_EX]: begin
                sel_cause = cause[STG_EX*EXW +: EXW];
                sel_pc    = pc[STG_EX*XLEN +: XLEN];
                sel_tval  = tval[STG_EX*XLEN +: XLEN];
            end
            grant[STG_ID]: begin
                sel_cause = cause[STG_ID*EXW +: EXW];
                sel_pc    = pc[STG_ID*XLEN +: XLEN];
                sel_tval  = tval[STG_ID*XLEN +: XLEN];
            end
            grant[STG_IF]: begin
                sel_cause = cause[STG_IF*EXW +: EXW];
                sel_pc    = pc[STG_IF*XLEN +: XLEN];
                sel_tval  = tval[STG_IF*XLEN +: XLEN];
            end
            default: begin
                sel_cause = '0;
            end
        endcase
    end

endmodule

// File: rtl/except_collector.sv
// except_collector: picks the oldest stage exception, quiesces the
// pipe, hands one trap record to the CSR unit and redirects fetch.
module except_collector
    import except_collector_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int EXW       = EXW_DEF,
    parameter int DRAIN_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NSTG-1:0]      stg_exc_valid,
    input  logic [NSTG*EXW-1:0]  stg_exc_cause,
    input  logic [NSTG*XLEN-1:0] stg_exc_pc,
    input  logic [NSTG*XLEN-1:0] stg_exc_tval,
    input  logic                 mret_req,
    input  logic [XLEN-1:0]      csr_mepc,
    input  logic                 mem_idle,
    output logic                 exc_valid,
    output logic [EXW-1:0]       exc_cause,
    output logic [XLEN-1:0]      exc_epc,
    output logic [XLEN-1:0]      exc_tval,
    input  logic                 exc_ready,
    input  logic [XLEN-1:0]      trap_vector,
    output logic                 pipe_kill,
    output logic                 pipe_stall,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_addr
);

    localparam int CW = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX + 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_MAX - 1);

    state_t          state;
    logic [CW-1:0]   drain_cnt;
    logic [EXW-1:0]  rec_cause;
    logic [XLEN-1:0] rec_pc;
    logic [XLEN-1:0] rec_tval;

    logic [NSTG-1:0] grant;
    logic [EXW-1:0]  sel_cause;
    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] sel_tval;
    logic            take;
    logic            drain_done;

    exc_prio_sel #(
        .XLEN (XLEN),
        .EXW  (EXW)
    ) u_prio (
        .valid     (stg_exc_valid),
        .cause     (stg_exc_cause),
        .pc        (stg_exc_pc),
        .tval      (stg_exc_tval),
        .grant     (grant),
        .sel_cause (sel_cause),
        .sel_pc    (sel_pc),
        .sel_tval  (sel_tval)
    );

    assign take       = |grant;
    assign drain_done = mem_idle || (drain_cnt >= DRAIN_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            drain_cnt      <= '0;
            rec_cause      <= '0;
            rec_pc         <= '0;
            rec_tval       <= '0;
            exc_valid      <= 1'b0;
            exc_cause      <= '0;
            exc_epc        <= '0;
            exc_tval       <= '0;
            pipe_kill      <= 1'b0;
            pipe_stall     <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // A trap kills the MRET in flight, so it wins.
                    if (take) begin
                        rec_cause  <= sel_cause;
                        rec_pc     <= sel_pc;
                        rec_tval   <= sel_tval;
                        pipe_kill  <= 1'b1;
                        pipe_stall <= 1'b1;
                        state      <= S_KILL;
                    end else if (mret_req) begin
                        redirect_valid <= 1'b1;
                        redirect_addr  <= csr_mepc;
                        state          <= S_REDIR;
                    end
                end
                S_KILL: begin
                    pipe_kill <= 1'b0;
                    drain_cnt <= '0;
                    state     <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        drain_cnt <= '0;
                        exc_valid <= 1'b1;
                        exc_cause <= rec_cause;
                        exc_epc   <= rec_pc;
                        exc_tval  <= rec_tval;
                        state     <= S_REPORT;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_REPORT: begin
                    if (exc_ready) begin
                        exc_valid      <= 1'b0;
                        exc_cause      <= '0;
                        exc_epc        <= '0;
                        exc_tval       <= '0;
                        pipe_stall     <= 1'b0;
                        redirect_valid <= 1'b1;
                        redirect_addr  <= trap_vector;
                        state          <= S_REDIR;
                    end
                end
                S_REDIR: begin
                    redirect_valid <= 1'b0;
                    redirect_addr  <= '0;
                    state          <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_except_collector.sv
// Directed bench for except_collector: trap timing, priority,
// backpressure, drain watchdog, MRET and mid-sequence reset.
module tb_except_collector;
    import except_collector_pkg::*;

    localparam int XLEN = 32;
    localparam int EXW  = 4;

    logic                 clk;
    logic                 reset_n;
    logic [NSTG-1:0]      stg_exc_valid;
    logic [NSTG*EXW-1:0]  stg_exc_cause;
    logic [NSTG*XLEN-1:0] stg_exc_pc;
    logic [NSTG*XLEN-1:0] stg_exc_tval;
    logic                 mret_req;
    logic [XLEN-1:0]      csr_mepc;
    logic                 mem_idle;
    logic                 exc_valid;
    logic [EXW-1:0]       exc_cause;
    logic [XLEN-1:0]      exc_epc;
    logic [XLEN-1:0]      exc_tval;
    logic                 exc_ready;
    logic [XLEN-1:0]      trap_vector;
    logic                 pipe_kill;
    logic                 pipe_stall;
    logic                 redirect_valid;
    logic [XLEN-1:0]      redirect_addr;

    int n_chk;
    int n_err;

    except_collector #(
        .XLEN      (XLEN),
        .EXW       (EXW),
        .DRAIN_MAX (15)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stg_exc_valid  (stg_exc_valid),
        .stg_exc_cause  (stg_exc_cause),
        .stg_exc_pc     (stg_exc_pc),
        .stg_exc_tval   (stg_exc_tval),
        .mret_req       (mret_req),
        .csr_mepc       (csr_mepc),
        .mem_idle       (mem_idle),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_epc        (exc_epc),
        .exc_tval       (exc_tval),
        .exc_ready      (exc_ready),
        .trap_vector    (trap_vector),
        .pipe_kill      (pipe_kill),
        .pipe_stall     (pipe_stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stg(input int idx, input logic [EXW-1:0] c,
                           input logic [XLEN-1:0] p,
                           input logic [XLEN-1:0] t);
        stg_exc_valid[idx]             = 1'b1;
        stg_exc_cause[idx*EXW +: EXW]  = c;
        stg_exc_pc[idx*XLEN +: XLEN]   = p;
        stg_exc_tval[idx*XLEN +: XLEN] = t;
    endtask

    task automatic clr_stg();
        stg_exc_valid = '0;
        stg_exc_cause = '0;
        stg_exc_pc    = '0;
        stg_exc_tval  = '0;
    endtask

    initial begin
        int n;
        int nred;
        int nexc;
        n_chk       = 0;
        n_err       = 0;
        reset_n     = 1'b0;
        clr_stg();
        mret_req    = 1'b0;
        csr_mepc    = '0;
        mem_idle    = 1'b1;
        exc_ready   = 1'b1;
        trap_vector = '0;
        step();
        step();
        chk("rst_exc_valid", 64'(exc_valid), 64'd0);
        chk("rst_kill", 64'(pipe_kill), 64'd0);
        chk("rst_stall", 64'(pipe_stall), 64'd0);
        chk("rst_redir", 64'(redirect_valid), 64'd0);
        chk("rst_redir_addr", 64'(redirect_addr), 64'd0);
        chk("rst_epc", 64'(exc_epc), 64'd0);
        reset_n = 1'b1;
        step();

        // EX-only exception, ideal latency
        set_stg(STG_EX, CAUSE_ILLEGAL, 32'h100, 32'h0);
        trap_vector = 32'h80;
        step();
        clr_stg();
        chk("t1_c1_kill", 64'(pipe_kill), 64'd1);
        chk("t1_c1_stall", 64'(pipe_stall), 64'd1);
        chk("t1_c1_valid", 64'(exc_valid), 64'd0);
        step();
        chk("t1_c2_kill", 64'(pipe_kill), 64'd0);
        chk("t1_c2_stall", 64'(pipe_stall), 64'd1);
        chk("t1_c2_valid", 64'(exc_valid), 64'd0);
        step();
        chk("t1_c3_valid", 64'(exc_valid), 64'd1);
        chk("t1_c3_cause", 64'(exc_cause), 64'd2);
        chk("t1_c3_epc", 64'(exc_epc), 64'h100);
        chk("t1_c3_tval", 64'(exc_tval), 64'h0);
        chk("t1_c3_redir", 64'(redirect_valid), 64'd0);
        step();
        chk("t1_c4_redir", 64'(redirect_valid), 64'd1);
        chk("t1_c4_addr", 64'(redirect_addr), 64'h80);
        chk("t1_c4_valid", 64'(exc_valid), 64'd0);
        chk("t1_c4_stall", 64'(pipe_stall), 64'd0);
        step();
        chk("t1_c5_redir", 64'(redirect_valid), 64'd0);

        // IF and MEM together: MEM wins, IF never reported
        set_stg(STG_IF, CAUSE_INSN_FAULT, 32'h204, 32'hAA);
        set_stg(STG_MEM, CAUSE_LOAD_FAULT, 32'h1F8, 32'hDEAD);
        trap_vector = 32'h90;
        step();
        clr_stg();
        step();
        step();
        chk("t2_valid", 64'(exc_valid), 64'd1);
        chk("t2_cause", 64'(exc_cause), 64'd5);
        chk("t2_epc", 64'(exc_epc), 64'h1F8);
        chk("t2_tval", 64'(exc_tval), 64'hDEAD);
        step();
        chk("t2_addr", 64'(redirect_addr), 64'h90);
        nexc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (exc_valid) nexc++;
        end
        chk("t2_if_dropped", 64'(nexc), 64'd0);

        // Backpressure: ready low for 3 REPORT cycles
        exc_ready   = 1'b0;
        trap_vector = 32'h999;
        set_stg(STG_ID, CAUSE_BREAKPOINT, 32'h40, 32'h44);
        step();
        clr_stg();
        step();
        step();
        nred = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_valid", 64'(exc_valid), 64'd1);
            chk("t3_hold_cause", 64'(exc_cause), 64'd3);
            chk("t3_hold_epc", 64'(exc_epc), 64'h40);
            chk("t3_hold_tval", 64'(exc_tval), 64'h44);
            chk("t3_hold_stall", 64'(pipe_stall), 64'd1);
            if (i == 1) set_stg(STG_MEM, CAUSE_STORE_FAULT, 32'h7, 32'h7);
            if (i == 2) clr_stg();
            if (i == 3) begin
                exc_ready   = 1'b1;
                trap_vector = 32'h200;
            end
            step();
        end
        chk("t3_valid_drop", 64'(exc_valid), 64'd0);
        chk("t3_addr", 64'(redirect_addr), 64'h200);
        for (int i = 0; i < 6; i++) begin
            if (redirect_valid) nred++;
            if (exc_valid) nred += 100;
            step();
        end
        chk("t3_one_redir", 64'(nred), 64'd1);

        // Drain watchdog with mem_idle held low
        mem_idle = 1'b0;
        set_stg(STG_IF, CAUSE_INSN_MISALIGN, 32'h10, 32'h11);
        trap_vector = 32'h300;
        step();
        clr_stg();
        chk("t4_kill", 64'(pipe_kill), 64'd1);
        step();
        n = 0;
        while (!exc_valid && n < 40) begin
            n++;
            step();
        end
        chk("t4_drain_len", 64'(n), 64'd15);
        chk("t4_cause", 64'(exc_cause), 64'd0);
        chk("t4_epc", 64'(exc_epc), 64'h10);
        mem_idle = 1'b1;
        step();
        chk("t4_redir", 64'(redirect_valid), 64'd1);
        step();

        // MRET alone
        mret_req = 1'b1;
        csr_mepc = 32'h3C0;
        step();
        mret_req = 1'b0;
        csr_mepc = 32'h111;
        chk("t5_redir", 64'(redirect_valid), 64'd1);
        chk("t5_addr", 64'(redirect_addr), 64'h3C0);
        chk("t5_valid", 64'(exc_valid), 64'd0);
        chk("t5_kill", 64'(pipe_kill), 64'd0);
        step();
        chk("t5_redir_off", 64'(redirect_valid), 64'd0);
        chk("t5_valid2", 64'(exc_valid), 64'd0);
        step();

        // MRET with ID exception: trap path only
        mret_req    = 1'b1;
        csr_mepc    = 32'h555;
        trap_vector = 32'h84;
        set_stg(STG_ID, CAUSE_ILLEGAL, 32'h80, 32'h13);
        step();
        mret_req = 1'b0;
        clr_stg();
        chk("t6_no_redir", 64'(redirect_valid), 64'd0);
        chk("t6_kill", 64'(pipe_kill), 64'd1);
        step();
        step();
        chk("t6_valid", 64'(exc_valid), 64'd1);
        chk("t6_cause", 64'(exc_cause), 64'd2);
        chk("t6_epc", 64'(exc_epc), 64'h80);
        step();
        chk("t6_addr", 64'(redirect_addr), 64'h84);
        step();

        // Reset during REPORT
        exc_ready = 1'b0;
        set_stg(STG_EX, CAUSE_LOAD_MISALIGN, 32'h120, 32'h121);
        step();
        clr_stg();
        step();
        step();
        chk("t7_in_report", 64'(exc_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t7_async_valid", 64'(exc_valid), 64'd0);
        chk("t7_async_stall", 64'(pipe_stall), 64'd0);
        chk("t7_async_epc", 64'(exc_epc), 64'd0);
        exc_ready = 1'b1;
        step();
        reset_n = 1'b1;
        nred = 0;
        nexc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (redirect_valid) nred++;
            if (exc_valid) nexc++;
        end
        chk("t7_no_redir", 64'(nred), 64'd0);
        chk("t7_no_exc", 64'(nexc), 64'd0);
        set_stg(STG_EX, CAUSE_LOAD_MISALIGN, 32'h300, 32'h301);
        trap_vector = 32'h400;
        step();
        clr_stg();
        step();
        step();
        chk("t7_fresh_valid", 64'(exc_valid), 64'd1);
        chk("t7_fresh_cause", 64'(exc_cause), 64'd4);
        chk("t7_fresh_epc", 64'(exc_epc), 64'h300);
        step();
        chk("t7_fresh_redir", 64'(redirect_valid), 64'd1);
        chk("t7_fresh_addr", 64'(redirect_addr), 64'h400);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
